// File: rtl/sysbus_arb_pkg.sv
// Shared state encoding and line-transaction constants for the sysbus round-robin arbiter.
package sysbus_arb_pkg;

   typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} arb_state_t;

   localparam int TAG_RW_BIT     = 12;
   localparam int BEATS_PER_LINE = 8;

endpackage

// File: rtl/sysbus_rr_arbiter_pick.sv
// rr_pick2: combinational 2-way round-robin picker; the client that did not win last time
// has priority on a tie.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      gnt_valid = |req;
      gnt_id    = 1'b0;
      case (req)
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last;
         default: gnt_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: shares one sysbus port between fetch (client 0) and data (client 1),
// holding the grant for a header plus BEATS data beats. SYSBUS_ARB_PERF_EN adds grant counters.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

module sysbus_rr_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = BEATS_PER_LINE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reqcyc0,
   input  logic                      reqcyc1,
   output logic                      reqack0,
   output logic                      reqack1,
   input  logic [BUS_DATA_WIDTH-1:0] req0,
   input  logic [BUS_DATA_WIDTH-1:0] req1,
   input  logic [BUS_TAG_WIDTH-1:0]  reqtag0,
   input  logic [BUS_TAG_WIDTH-1:0]  reqtag1,
   output logic                      respcyc0,
   output logic                      respcyc1,
   input  logic                      respack0,
   input  logic                      respack1,
   output logic [BUS_DATA_WIDTH-1:0] resp0,
   output logic [BUS_DATA_WIDTH-1:0] resp1,
   output logic [BUS_TAG_WIDTH-1:0]  resptag0,
   output logic [BUS_TAG_WIDTH-1:0]  resptag1,
   output logic                      bus_reqcyc,
   input  logic                      bus_reqack,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_respcyc,
   output logic                      bus_respack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      owner,
   output logic                      busy,
`ifdef SYSBUS_ARB_PERF_EN
   output logic [31:0]               grant_cnt0,
   output logic [31:0]               grant_cnt1,
`endif
   output logic                      err_stray_resp
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   arb_state_t        state;
   logic [BEAT_W-1:0] beat;
   logic              last_grant;
   logic              gnt_valid;
   logic              gnt_id;

   logic                      own_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
   logic                      own_respack;
   logic                      fwd_req;
   logic                      fwd_resp;
   logic                      req_hs;
   logic                      resp_hs;

   rr_pick2 u_pick (
      .req       ({reqcyc1, reqcyc0}),
      .last      (last_grant),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign own_reqcyc  = owner ? reqcyc1  : reqcyc0;
   assign own_req     = owner ? req1     : req0;
   assign own_reqtag  = owner ? reqtag1  : reqtag0;
   assign own_respack = owner ? respack1 : respack0;
   assign fwd_req     = (state == HDR) || (state == WDATA);
   assign fwd_resp    = (state == RDATA);
   assign busy        = (state != IDLE);

   // Pure routing: nothing is buffered, the non-owner side always sees zeros.
   always_comb begin
      bus_reqcyc  = fwd_req && own_reqcyc;
      bus_req     = fwd_req ? own_req    : '0;
      bus_reqtag  = fwd_req ? own_reqtag : '0;
      reqack0     = fwd_req && !owner && bus_reqack;
      reqack1     = fwd_req &&  owner && bus_reqack;
      bus_respack = fwd_resp && own_respack;
      respcyc0    = fwd_resp && !owner && bus_respcyc;
      respcyc1    = fwd_resp &&  owner && bus_respcyc;
      resp0       = (fwd_resp && !owner) ? bus_resp    : '0;
      resp1       = (fwd_resp &&  owner) ? bus_resp    : '0;
      resptag0    = (fwd_resp && !owner) ? bus_resptag : '0;
      resptag1    = (fwd_resp &&  owner) ? bus_resptag : '0;
   end

   assign req_hs  = bus_reqack && bus_reqcyc;
   assign resp_hs = bus_respcyc && bus_respack;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         beat           <= '0;
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         err_stray_resp <= 1'b0;
      end else begin
         if (bus_respcyc && state != RDATA)
            err_stray_resp <= 1'b1;
         case (state)
            IDLE: if (gnt_valid) begin
               owner <= gnt_id;
               state <= HDR;
            end
            HDR: if (req_hs) begin
               beat  <= '0;
               state <= (own_reqtag[TAG_RW_BIT] == `SYSBUS_WRITE) ? WDATA : RDATA;
            end
            WDATA: if (req_hs) begin
               if (beat == LAST_BEAT) begin
                  beat       <= '0;
                  state      <= IDLE;
                  last_grant <= owner;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            RDATA: if (resp_hs) begin
               if (beat == LAST_BEAT) begin
                  beat       <= '0;
                  state      <= IDLE;
                  last_grant <= owner;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SYSBUS_ARB_PERF_EN
   // Counts grants (entries into HDR) per client, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (state == IDLE && gnt_valid) begin
         if (!gnt_id && grant_cnt0 != 32'hFFFF_FFFF)
            grant_cnt0 <= grant_cnt0 + 32'd1;
         if (gnt_id && grant_cnt1 != 32'hFFFF_FFFF)
            grant_cnt1 <= grant_cnt1 + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Scoreboard bench for sysbus_rr_arbiter: stimulus pushes expected bus words and client
// responses into queues; a negedge monitor pops and compares on every handshake.
module tb_sysbus_rr_arbiter;

   localparam int DW    = 64;
   localparam int TW    = 13;
   localparam int BEATS = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          reqcyc0, reqcyc1, reqack0, reqack1;
   logic [DW-1:0] req0, req1;
   logic [TW-1:0] reqtag0, reqtag1;
   logic          respcyc0, respcyc1, respack0, respack1;
   logic [DW-1:0] resp0, resp1;
   logic [TW-1:0] resptag0, resptag1;
   logic          bus_reqcyc, bus_reqack;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_respcyc, bus_respack;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;
   logic          owner, busy, err_stray_resp;
`ifdef SYSBUS_ARB_PERF_EN
   logic [31:0]   grant_cnt0, grant_cnt1;
`endif

   typedef struct packed {
      logic          c;
      logic [DW-1:0] d;
      logic [TW-1:0] t;
   } exp_t;

   exp_t req_q[$];
   exp_t resp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sysbus_rr_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .reqcyc0        (reqcyc0),
      .reqcyc1        (reqcyc1),
      .reqack0        (reqack0),
      .reqack1        (reqack1),
      .req0           (req0),
      .req1           (req1),
      .reqtag0        (reqtag0),
      .reqtag1        (reqtag1),
      .respcyc0       (respcyc0),
      .respcyc1       (respcyc1),
      .respack0       (respack0),
      .respack1       (respack1),
      .resp0          (resp0),
      .resp1          (resp1),
      .resptag0       (resptag0),
      .resptag1       (resptag1),
      .bus_reqcyc     (bus_reqcyc),
      .bus_reqack     (bus_reqack),
      .bus_req        (bus_req),
      .bus_reqtag     (bus_reqtag),
      .bus_respcyc    (bus_respcyc),
      .bus_respack    (bus_respack),
      .bus_resp       (bus_resp),
      .bus_resptag    (bus_resptag),
      .owner          (owner),
      .busy           (busy),
`ifdef SYSBUS_ARB_PERF_EN
      .grant_cnt0     (grant_cnt0),
      .grant_cnt1     (grant_cnt1),
`endif
      .err_stray_resp (err_stray_resp)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_req(input logic c, input logic [DW-1:0] d, input logic [TW-1:0] t);
      exp_t e;
      e.c = c; e.d = d; e.t = t;
      req_q.push_back(e);
   endtask

   task automatic drive(input logic c, input logic cyc, input logic [DW-1:0] d, input logic [TW-1:0] t);
      if (c) begin reqcyc1 = cyc; req1 = d; reqtag1 = t; end
      else   begin reqcyc0 = cyc; req0 = d; reqtag0 = t; end
   endtask

   task automatic issue(input logic c, input logic [DW-1:0] addr, input logic [TW-1:0] t);
      push_req(c, addr, t);
      drive(c, 1'b1, addr, t);
   endtask

   task automatic wait_req_hs();
      logic hs = 1'b0;
      for (int i = 0; i < 32 && !hs; i++) begin
         @(negedge clk);
         hs = bus_reqcyc && bus_reqack;
         @(posedge clk); #1;
      end
      check("req_hs_seen", hs, 1'b1);
   endtask

   task automatic rd_beats(input logic c, input logic [DW-1:0] base, input logic [TW-1:0] t);
      for (int i = 0; i < BEATS; i++) begin
         exp_t e;
         e.c = c; e.d = base + DW'(i); e.t = t;
         resp_q.push_back(e);
         bus_respcyc = 1'b1; bus_resp = e.d; bus_resptag = t;
         @(posedge clk); #1;
      end
      bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
   endtask

   // Header then n-1 data words 0xD000+w; reqack of the client must mirror bus_reqack.
   task automatic do_write(input logic c, input logic [DW-1:0] addr, input logic [TW-1:0] t,
                           input int n, input logic toggle);
      int   w = 0;
      logic hs;
      for (int k = 0; k < n; k++) push_req(c, (k == 0) ? addr : 64'hD000 + DW'(k), t);
      for (int cyc = 0; cyc < 64 && w < n; cyc++) begin
         drive(c, 1'b1, (w == 0) ? addr : 64'hD000 + DW'(w), t);
         @(negedge clk);
         hs = bus_reqcyc && bus_reqack;
         if (bus_reqcyc) begin
            check("reqack_mirror", c ? reqack1 : reqack0, bus_reqack);
            check("reqack_nonowner", c ? reqack0 : reqack1, 1'b0);
         end
         @(posedge clk); #1;
         if (hs) w++;
         if (toggle) bus_reqack = ~bus_reqack;
      end
      check("wr_words_done", w, n);
   endtask

   // Monitor: every bus request handshake and client response handshake consumes one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_reqcyc && bus_reqack) begin
            if (req_q.size() == 0) check("unexpected_bus_req", req_q.size(), 1);
            else begin
               e = req_q.pop_front();
               check("bus_req", bus_req, e.d);
               check("bus_reqtag", bus_reqtag, e.t);
               check("reqack_owner", e.c ? reqack1 : reqack0, 1'b1);
               check("reqack_other", e.c ? reqack0 : reqack1, 1'b0);
            end
         end
         if ((respcyc0 && respack0) || (respcyc1 && respack1)) begin
            if (resp_q.size() == 0) check("unexpected_resp", resp_q.size(), 1);
            else begin
               e = resp_q.pop_front();
               check("resp_client", respcyc1, e.c);
               check("resp_data", e.c ? resp1 : resp0, e.d);
               check("resp_tag", e.c ? resptag1 : resptag0, e.t);
               check("respcyc_other", e.c ? respcyc0 : respcyc1, 1'b0);
               check("resp_other_zero", e.c ? resp0 : resp1, 64'h0);
               check("bus_respack", bus_respack, 1'b1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      reqcyc0 = 0; reqcyc1 = 0; req0 = '0; req1 = '0; reqtag0 = '0; reqtag1 = '0;
      respack0 = 1'b1; respack1 = 1'b1;
      bus_reqack = 1'b1; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_owner", owner, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_stray_resp, 1'b0);
      check("rst_bus_reqcyc", bus_reqcyc, 1'b0);
      check("rst_bus_respack", bus_respack, 1'b0);
      @(posedge clk); #1;

      // Client 0 read, beats 0x100..0x107.
      issue(1'b0, 64'h1000, 13'h0005);
      wait_req_hs();
      drive(1'b0, 1'b0, '0, '0);
      rd_beats(1'b0, 64'h100, 13'h0005);
      @(negedge clk);
      check("rd0_idle", busy, 1'b0);
      check("rd0_owner", owner, 1'b0);
      @(posedge clk); #1;

      // Client 1 write, 9 words, bus_reqack toggling every cycle.
      bus_reqack = 1'b0;
      do_write(1'b1, 64'h8000_0040, 13'h1003, 9, 1'b1);
      drive(1'b1, 1'b0, '0, '0);
      bus_reqack = 1'b1;
      @(negedge clk);
      check("wr1_idle", busy, 1'b0);
      check("wr1_owner", owner, 1'b1);
      @(posedge clk); #1;

      // Stray response pulse while IDLE.
      bus_respcyc = 1'b1; bus_resp = 64'hBAD;
      @(negedge clk);
      check("stray_respack", bus_respack, 1'b0);
      check("stray_respcyc0", respcyc0, 1'b0);
      @(posedge clk); #1;
      bus_respcyc = 1'b0; bus_resp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stray_err_sticky", err_stray_resp, 1'b1);
      @(posedge clk); #1;

      // Client 0 read so that last_grant becomes 0 before the mid-burst reset.
      issue(1'b0, 64'h1040, 13'h0007);
      wait_req_hs();
      drive(1'b0, 1'b0, '0, '0);
      rd_beats(1'b0, 64'h200, 13'h0007);
      check("stray_err_kept", err_stray_resp, 1'b1);

      // Client 0 write, reset asserted at WDATA beat 4.
      do_write(1'b0, 64'h40, 13'h1001, 5, 1'b0);
      reset = 1'b1; bus_reqack = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_owner", owner, 1'b0);
      check("mid_rst_err", err_stray_resp, 1'b0);
      check("mid_rst_bus_reqcyc", bus_reqcyc, 1'b0);
      check("mid_rst_bus_req", bus_req, 64'h0);
      check("mid_rst_reqack0", reqack0, 1'b0);
      check("mid_rst_respcyc0", respcyc0, 1'b0);

      // Both request after reset: 0, then 1, then 0 again.
      bus_reqack = 1'b1;
      issue(1'b0, 64'h2000, 13'h0011);
      issue(1'b1, 64'h3000, 13'h0022);
      @(posedge clk); #1;
      wait_req_hs();
      check("tie_first_owner", owner, 1'b0);
      push_req(1'b0, 64'h2000, 13'h0011);
      rd_beats(1'b0, 64'h300, 13'h0011);
      wait_req_hs();
      check("tie_second_owner", owner, 1'b1);
      rd_beats(1'b1, 64'h400, 13'h0022);
      wait_req_hs();
      check("tie_third_owner", owner, 1'b0);
      drive(1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, '0);
      rd_beats(1'b0, 64'h500, 13'h0011);

      // One more grant to each client: totals since reset are 3 and 2.
      issue(1'b1, 64'h4000, 13'h0033);
      wait_req_hs();
      drive(1'b1, 1'b0, '0, '0);
      rd_beats(1'b1, 64'h600, 13'h0033);
      issue(1'b0, 64'h5000, 13'h0044);
      wait_req_hs();
      drive(1'b0, 1'b0, '0, '0);
      rd_beats(1'b0, 64'h700, 13'h0044);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("final_idle", busy, 1'b0);
      check("req_q_drained", req_q.size(), 0);
      check("resp_q_drained", resp_q.size(), 0);
`ifdef SYSBUS_ARB_PERF_EN
      check("grant_cnt0", grant_cnt0, 32'd3);
      check("grant_cnt1", grant_cnt1, 32'd2);
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sysbus_rr_arbiter.md
Name: sysbus_rr_arbiter

Overview:
Pass-through round-robin arbiter that shares the single sysbus port between two sysbus clients: 0 = instruction fetch, 1 = data access. It grants one client at a time and locks the grant for a complete transaction: a header plus 8 write beats, or a header plus 8 read response beats. It never buffers line data; every beat is routed combinationally between the owner and the bus. It sits between the fetch/data caches and the top-level sysbus pins.

Parameters:
BUS_DATA_WIDTH, 64, width of req/resp data words
BUS_TAG_WIDTH, 13, width of req/resp tags; bit 12 is the read/write flag
BEATS, 8, data beats per line transaction (512-bit line / 64)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reqcyc0 / reqcyc1  in  1  client request valid
reqack0 / reqack1  out  1  bus reqack, routed to the owner only
req0 / req1  in  BUS_DATA_WIDTH  client address or write data
reqtag0 / reqtag1  in  BUS_TAG_WIDTH  client request tag
respcyc0 / respcyc1  out  1  response valid, routed to the owner only
respack0 / respack1  in  1  client response acknowledge
resp0 / resp1  out  BUS_DATA_WIDTH  response data; 0 when not owner
resptag0 / resptag1  out  BUS_TAG_WIDTH  response tag; 0 when not owner
bus_reqcyc  out  1  sysbus request valid
bus_reqack  in  1  sysbus request acknowledge
bus_req  out  BUS_DATA_WIDTH  sysbus request word
bus_reqtag  out  BUS_TAG_WIDTH  sysbus request tag
bus_respcyc  in  1  sysbus response valid
bus_respack  out  1  sysbus response acknowledge
bus_resp  in  BUS_DATA_WIDTH  sysbus response data
bus_resptag  in  BUS_TAG_WIDTH  sysbus response tag
owner  out  1  current/last grantee
busy  out  1  high in any non-IDLE state
err_stray_resp  out  1  sticky: bus_respcyc seen outside RDATA

Behaviour:
- Reset, taking effect on the next cycle, including mid-burst:
  - state=IDLE, beat=0, last_grant=1 so client 0 wins first, owner=0, err_stray_resp=0.
  - All outputs are 0.
- States: IDLE, HDR, WDATA, RDATA.
- IDLE: choose a grantee from the reqcyc inputs.
  - Only one reqcyc asserted: that client is the grantee.
  - Both asserted: grantee = !last_grant.
  - Grant is registered: owner<=grantee and state<=HDR. Nothing is forwarded in IDLE.
  - Minimum one-cycle arbitration latency.
- HDR: the owner's reqcyc, req and reqtag drive bus_reqcyc, bus_req and bus_reqtag; bus_reqack drives the owner's reqack.
  - On bus_reqack&&bus_reqcyc with owner reqtag[12]==`SYSBUS_WRITE: latch write flag, beat<=0, go to WDATA.
  - On the same handshake for a read: beat<=0, go to RDATA.
- WDATA: same forwarding as HDR.
  - Each bus_reqack&&bus_reqcyc does beat<=beat+1.
  - At beat==BEATS-1 with handshake: go to IDLE, last_grant<=owner.
- RDATA: bus_req* = 0; bus_respcyc, bus_resp and bus_resptag are forwarded to the owner; owner respack drives bus_respack.
  - Each bus_respcyc&&respack does beat++.
  - Last beat: go to IDLE, last_grant<=owner.
- Non-owner: reqack, respcyc, resp and resptag held 0 at all times.
- Owner drops reqcyc mid-burst: bus_reqcyc follows to 0; state and beat unchanged, and the transaction waits.
- bus_respcyc in IDLE, HDR or WDATA: bus_respack=0, err_stray_resp<=1, cleared only by reset.
- Beat counter is $clog2(BEATS) bits and is used unsigned. beat does not wrap inside a burst; the terminal transition resets it.
- Fairness: a waiting client is granted after at most one foreign transaction.

Optional Feature:
SYSBUS_ARB_PERF_EN:
- Defined: adds outputs grant_cnt0 and grant_cnt1 (32 bits each, reset 0). Each increments on entry to HDR for that client and saturates at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sysbus_arb_pkg:
  - typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} arb_state_t
  - constants TAG_RW_BIT=12 and BEATS_PER_LINE=8
- Sub-module rr_pick2: pure combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs gnt_valid and gnt_id. Reusable for the future N-way version.

Test Plan:
- reqcyc0 only, read tag, bus acks header, then 8 bus_respcyc beats with resp=0x100+i.
  -> resp0 shows 0x100..0x107, respcyc1 stays 0, then IDLE and owner=0.
- Both reqcyc high right after reset.
  -> client 0 granted first; client 1 granted immediately after client 0's last beat; a third simultaneous request then goes to 0.
- Write from client 1: header addr 0x8000_0040 plus 8 data words, bus_reqack toggling every other cycle.
  -> bus_req carries exactly 9 words in order and reqack1 mirrors bus_reqack.
- bus_respcyc pulse while IDLE.
  -> bus_respack=0 and err_stray_resp=1 persists until reset.
- Reset asserted during WDATA beat 4.
  -> next cycle state=IDLE, all outputs 0, client 0 wins the next tie.
- With SYSBUS_ARB_PERF_EN defined: 3 grants to client 0 and 2 to client 1.
  -> grant_cnt0=3 and grant_cnt1=2.
